if_id_pipe: RTL
===============

IF_ID_PIPE -- requirements
Module: if_id_pipe

Interface
REQ-001 Parameter XLEN, default 32: PC+4 width in bits.
REQ-002 Parameter ILEN, default 32: instruction width in bits.
REQ-003 Parameter NOP_INSTR, default all-zero (ILEN bits): bubble instruction value.
REQ-004 Parameter CNT_W, default 16: performance counter width.
REQ-005 Port clk, input, 1: single clock; all state SHALL update on its falling edge only.
REQ-006 Port rst, input, 1: reset, synchronous, active-high.
REQ-007 Port in_valid, input, 1: fetch stage offers in_pc4/in_instr.
REQ-008 Port in_ready, output, 1: block accepts; registered output, no combinational path from out_ready.
REQ-009 Port in_pc4, input, XLEN: PC+4 from fetch.
REQ-010 Port in_instr, input, ILEN: fetched instruction.
REQ-011 Port flush, input, 1: discard all held entries (branch/jump taken).
REQ-012 Port out_valid, output, 1: out_pc4/out_instr are a real instruction.
REQ-013 Port out_ready, input, 1: decode accepts; low means decode stall.
REQ-014 Port out_pc4, output, XLEN; out_instr, output, ILEN: head entry to decode.

Function
REQ-015 Transfer in SHALL occur on a falling edge where in_valid and in_ready are high; transfer out where out_valid and out_ready are high.
REQ-016 Storage SHALL be two entries (main, skid); occupancy state machine EMPTY, ONE, TWO.
REQ-017 EMPTY: in-transfer -> ONE. ONE: in only -> TWO; out only -> EMPTY; both -> ONE (new entry replaces head). TWO: out -> ONE (skid becomes head); no in-transfer possible.
REQ-018 in_ready SHALL be high in EMPTY and ONE, low in TWO; out_valid SHALL be high in ONE and TWO.
REQ-019 Latency SHALL be one falling edge from accept to out_valid when EMPTY; order SHALL be strictly FIFO.
REQ-020 When out_valid is low, out_instr SHALL equal NOP_INSTR and out_pc4 SHALL be zero.
REQ-021 Head outputs SHALL hold stable while out_valid and not out_ready.
REQ-022 flush SHALL force EMPTY on that edge; an in-transfer in the same cycle SHALL be dropped; an out-transfer in the same cycle completes.
REQ-023 Full throughput (one instruction per cycle) SHALL be sustained while out_ready stays high.

Reset
REQ-024 rst SHALL, on the falling edge it is sampled high, force EMPTY, out_valid=0, out_instr=NOP_INSTR, out_pc4=0, in_ready=1, counters zero.
REQ-025 rst SHALL take priority over flush and any transfer, including mid-operation in state TWO.

Configuration
REQ-026 Macro IF_ID_PIPE_PERF_EN defined: outputs stall_cnt and flush_cnt (CNT_W each) SHALL exist; stall_cnt increments each edge with out_valid high and out_ready low; flush_cnt increments each edge with flush high; both saturate at all-ones.
REQ-027 Macro undefined: these ports and counters SHALL be absent; all other behaviour identical.

Structure
REQ-028 Package if_id_pkg SHALL hold default XLEN/ILEN, NOP_INSTR constant and the occupancy state typedef.
REQ-029 Sub-module if_id_sat_cnt (saturating counter, width param, inc, clear) SHALL be instantiated twice, only under IF_ID_PIPE_PERF_EN.

Verification
REQ-030 Reset, then in_valid with pc4=0x00400004, instr=0x8C080000, out_ready=1 -> next edge out_valid=1 carrying those values; in_ready stays 1.
REQ-031 out_ready=0, push 0x11/0x22 then 0x33/0x44 -> state TWO, in_ready=0, head 0x11/0x22 stable; out_ready=1 -> 0x33/0x44 follows next edge, in_ready=1.
REQ-032 State TWO with flush=1 and in_valid=1 -> next edge out_valid=0, out_instr=0x00000000, incoming entry never appears.
REQ-033 Stream 8 instructions with out_ready=1 -> 8 consecutive out_valid cycles, in order, no gaps.
REQ-034 rst asserted in state TWO -> next edge EMPTY, outputs at reset values; with IF_ID_PIPE_PERF_EN, stall_cnt=0.
REQ-035 IF_ID_PIPE_PERF_EN, CNT_W=4, hold out_ready=0 with out_valid=1 for 20 cycles -> stall_cnt=15, no wrap.

Source files
------------

// File: rtl/if_id_pkg.sv
// Shared defaults and occupancy encoding for the IF/ID pipeline register.
package if_id_pkg;

  localparam int IF_ID_XLEN = 32;
  localparam int IF_ID_ILEN = 32;

  // Bubble presented to decode whenever no real instruction is held.
  localparam logic [IF_ID_ILEN-1:0] IF_ID_NOP_INSTR = '0;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } occ_state_t;

endpackage

// File: rtl/if_id_sat_cnt.sv
// Saturating up-counter; clear has priority over increment.
// Updates on the falling clock edge like the rest of the IF/ID stage.
module if_id_sat_cnt #(
  parameter int W = 16
)(
  input  logic         clk,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] r_cnt;

  // Count up, stick at all-ones, zero on clear.
  always_ff @(negedge clk) begin
    if (clear)                   r_cnt <= '0;
    else if (inc && r_cnt != '1) r_cnt <= r_cnt + W'(1);
  end

  assign cnt = r_cnt;

endmodule

// File: rtl/if_id_pipe.sv
// IF/ID pipeline register: two-entry skid buffer between fetch and decode.
// All state changes on the falling edge of clk; rst is synchronous, active high.
// Optional macro IF_ID_PIPE_PERF_EN adds saturating stall/flush counters.
module if_id_pipe import if_id_pkg::*; #(
  parameter int              XLEN      = IF_ID_XLEN,
  parameter int              ILEN      = IF_ID_ILEN,
  parameter logic [ILEN-1:0] NOP_INSTR = ILEN'(IF_ID_NOP_INSTR),
  parameter int              CNT_W     = 16
)(
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc4,
  input  logic [ILEN-1:0] in_instr,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc4,
  output logic [ILEN-1:0] out_instr
`ifdef IF_ID_PIPE_PERF_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  occ_state_t      r_state, w_state_nxt;
  logic [XLEN-1:0] r_head_pc4, r_skid_pc4;
  logic [ILEN-1:0] r_head_instr, r_skid_instr;

  logic w_in_xfer, w_out_xfer;
  logic w_ld_head_in, w_ld_head_skid, w_ld_skid;

  // Handshake flags come straight off the state register, so in_ready has
  // no combinational dependence on out_ready.
  assign in_ready   = (r_state != ST_TWO);
  assign out_valid  = (r_state != ST_EMPTY);
  assign w_in_xfer  = in_valid & in_ready;
  assign w_out_xfer = out_valid & out_ready;

  // Next occupancy and which data register loads from where.
  // flush empties the buffer; an accepted fetch in that cycle is dropped,
  // a concurrent drain to decode simply completes.
  always_comb begin
    w_state_nxt    = r_state;
    w_ld_head_in   = 1'b0;
    w_ld_head_skid = 1'b0;
    w_ld_skid      = 1'b0;
    if (flush) begin
      w_state_nxt = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_in_xfer) begin
            w_state_nxt  = ST_ONE;
            w_ld_head_in = 1'b1;
          end
        end
        ST_ONE: begin
          if (w_in_xfer && w_out_xfer) begin
            w_ld_head_in = 1'b1;           // new entry replaces departing head
          end else if (w_in_xfer) begin
            w_state_nxt = ST_TWO;
            w_ld_skid   = 1'b1;
          end else if (w_out_xfer) begin
            w_state_nxt = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (w_out_xfer) begin
            w_state_nxt    = ST_ONE;
            w_ld_head_skid = 1'b1;         // skid entry moves up to head
          end
        end
        default: w_state_nxt = ST_EMPTY;
      endcase
    end
  end

  // Occupancy state register; reset beats flush and any transfer.
  always_ff @(negedge clk) begin
    if (rst) r_state <= ST_EMPTY;
    else     r_state <= w_state_nxt;
  end

  // Head/skid data registers, loaded only on the moves chosen above.
  always_ff @(negedge clk) begin
    if (rst) begin
      r_head_pc4   <= '0;
      r_head_instr <= NOP_INSTR;
      r_skid_pc4   <= '0;
      r_skid_instr <= NOP_INSTR;
    end else begin
      if (w_ld_head_in) begin
        r_head_pc4   <= in_pc4;
        r_head_instr <= in_instr;
      end else if (w_ld_head_skid) begin
        r_head_pc4   <= r_skid_pc4;
        r_head_instr <= r_skid_instr;
      end
      if (w_ld_skid) begin
        r_skid_pc4   <= in_pc4;
        r_skid_instr <= in_instr;
      end
    end
  end

  // Decode sees a clean bubble whenever nothing valid is held; stale head
  // contents never leak out.
  assign out_pc4   = out_valid ? r_head_pc4   : '0;
  assign out_instr = out_valid ? r_head_instr : NOP_INSTR;

`ifdef IF_ID_PIPE_PERF_EN
  logic w_stall_inc;
  assign w_stall_inc = out_valid & ~out_ready;

  if_id_sat_cnt #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .clear (rst),
    .inc   (w_stall_inc),
    .cnt   (stall_cnt)
  );

  if_id_sat_cnt #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .clear (rst),
    .inc   (flush),
    .cnt   (flush_cnt)
  );
`endif

endmodule
